// File: rtl/trig_sched.sv
// trig_sched: star-trigger scheduler.
// A CPU-programmed table of timed events is played back against a local
// timer. Each event drives a channel mask onto o_star for max(width,1)
// cycles.
//
// Ports:
//   clk, rst                 single clock, synchronous active-high reset
//   psel/penable/pwrite      APB slave control
//   paddr[7:0], pwdata[31:0] APB byte address / write data
//   prdata[31:0]             registered read data (captured in setup phase)
//   pready                   always 1
//   ext_start                asynchronous external start level
//   o_star[N_CH-1:0]         registered trigger pulses
//   busy                     sequencer not idle
//   irq                      one-cycle pulse on sequence completion
//
// Register map:
//   0x00 CTRL   [0] START (self-clearing), [1] ABORT (self-clearing), [2] LOOP
//   0x04 STATUS [0] busy, [1] DONE (W1C), [2] LATE (W1C), [11:8] entry index
//   0x08 COUNT  0x0C WIDX  0x10 TS (staging)
//   0x14 ENTRY  write-only; commits {TS, mask, width} to table[WIDX]
//
// Build option: define TRIG_SCHED_EXT_START_EN to let a synchronized rising
// edge of ext_start act as CTRL.START.
module trig_sched #(
  parameter int unsigned N_CH  = 17,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned TS_W  = 32,
  parameter int unsigned PW_W  = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            psel,
  input  logic            penable,
  input  logic            pwrite,
  input  logic [7:0]      paddr,
  input  logic [31:0]     pwdata,
  output logic [31:0]     prdata,
  output logic            pready,
  input  logic            ext_start,
  output logic [N_CH-1:0] o_star,
  output logic            busy,
  output logic            irq
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_FIRE,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic             loop_q;
  logic             done_q;
  logic             late_q;
  logic [CNT_W-1:0] count_q;
  logic [IDX_W-1:0] widx_q;
  logic [TS_W-1:0]  ts_stage_q;
  logic [IDX_W-1:0] idx_q;
  logic [TS_W-1:0]  timer_q;
  logic [PW_W-1:0]  fire_cnt_q;

  logic [TS_W-1:0]  tbl_ts   [DEPTH];
  logic [N_CH-1:0]  tbl_mask [DEPTH];
  logic [PW_W-1:0]  tbl_w    [DEPTH];

  logic             wr_en, rd_setup, cfg_wr, entry_wr;
  logic             ctrl_start, abort_req, start_req, ext_edge;
  logic [CNT_W-1:0] idx_nxt;
  logic [TS_W-1:0]  cur_ts;
  logic [PW_W-1:0]  cur_w;
  logic [31:0]      rd_val;

  assign pready   = 1'b1;
  assign busy     = (state_q != S_IDLE);
  assign wr_en    = psel & penable & pwrite;
  assign rd_setup = psel & ~penable & ~pwrite;
  // Table/config registers are frozen while a sequence is running.
  assign cfg_wr   = wr_en & ~busy;
  assign entry_wr = cfg_wr & (paddr == 8'h14) & ~rst;

  assign ctrl_start = wr_en & (paddr == 8'h00) & pwdata[0];
  assign abort_req  = wr_en & (paddr == 8'h00) & pwdata[1];
  assign start_req  = ctrl_start | ext_edge;

  assign cur_ts  = tbl_ts[idx_q];
  assign cur_w   = tbl_w[idx_q];
  assign idx_nxt = CNT_W'(idx_q) + CNT_W'(1);

`ifdef TRIG_SCHED_EXT_START_EN
  // Two synchronizer flops plus one history flop for the edge detector.
  logic [2:0] ext_sync_q;

  always_ff @(posedge clk) begin
    if (rst) ext_sync_q <= '0;
    else     ext_sync_q <= {ext_sync_q[1:0], ext_start};
  end

  assign ext_edge = ext_sync_q[1] & ~ext_sync_q[2];
`else
  logic unused_ext;
  assign unused_ext = ext_start;
  assign ext_edge   = 1'b0;
`endif

  logic unused_pwdata;
  assign unused_pwdata = ^pwdata;

  // Next-state logic. ABORT overrides every transition, including START.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start_req) state_d = S_LOAD;
      S_LOAD: state_d = (count_q == '0) ? S_DONE : S_WAIT;
      // ">=" folds the on-time and late cases into one transition.
      S_WAIT: if (timer_q >= cur_ts) state_d = S_FIRE;
      S_FIRE: begin
        if (fire_cnt_q == '0) state_d = (idx_nxt < count_q) ? S_WAIT : S_DONE;
      end
      S_DONE: state_d = loop_q ? S_LOAD : S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort_req) state_d = S_IDLE;
  end

  // Sequencer datapath and register file.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      loop_q     <= 1'b0;
      done_q     <= 1'b0;
      late_q     <= 1'b0;
      count_q    <= '0;
      widx_q     <= '0;
      ts_stage_q <= '0;
      idx_q      <= '0;
      timer_q    <= '0;
      fire_cnt_q <= '0;
      o_star     <= '0;
      irq        <= 1'b0;
      prdata     <= '0;
    end else begin
      state_q <= state_d;
      irq     <= (state_q == S_DONE) & ~abort_req;
      // o_star follows the state being entered, so a pulse starts the cycle
      // after the matching compare and drops as soon as FIRE is left.
      o_star  <= (state_d == S_FIRE) ? tbl_mask[idx_q] : '0;

      unique case (state_q)
        S_LOAD: begin
          timer_q <= '0;
          idx_q   <= '0;
        end
        S_WAIT, S_FIRE: begin
          if (timer_q != '1) timer_q <= timer_q + TS_W'(1);
        end
        default: ;
      endcase

      if (state_q == S_WAIT && state_d == S_FIRE) begin
        fire_cnt_q <= (cur_w == '0) ? '0 : cur_w - PW_W'(1);
        if (timer_q != cur_ts) late_q <= 1'b1;
      end else if (state_q == S_FIRE) begin
        if (fire_cnt_q == '0) idx_q <= idx_q + IDX_W'(1);
        else                  fire_cnt_q <= fire_cnt_q - PW_W'(1);
      end

      if (wr_en && paddr == 8'h00) loop_q <= pwdata[2];
      if (wr_en && paddr == 8'h04) begin
        if (pwdata[1]) done_q <= 1'b0;
        if (pwdata[2]) late_q <= 1'b0;
      end
      if (state_q == S_DONE && !abort_req) done_q <= 1'b1;

      if (cfg_wr) begin
        unique case (paddr)
          8'h08:   count_q    <= pwdata[CNT_W-1:0];
          8'h0C:   widx_q     <= pwdata[IDX_W-1:0];
          8'h10:   ts_stage_q <= pwdata[TS_W-1:0];
          8'h14:   widx_q     <= widx_q + IDX_W'(1);
          default: ;
        endcase
      end

      if (rd_setup) prdata <= rd_val;
    end
  end

  // Event table: not reset, written only through ENTRY.
  always_ff @(posedge clk) begin
    if (entry_wr) begin
      tbl_ts[widx_q]   <= ts_stage_q;
      tbl_mask[widx_q] <= pwdata[N_CH-1:0];
      tbl_w[widx_q]    <= pwdata[24 +: PW_W];
    end
  end

  // Read mux; ENTRY is write-only and reads as zero like unmapped space.
  always_comb begin
    rd_val = '0;
    unique case (paddr)
      8'h00: rd_val[2] = loop_q;
      8'h04: begin
        rd_val[0]          = busy;
        rd_val[1]          = done_q;
        rd_val[2]          = late_q;
        rd_val[8 +: IDX_W] = idx_q;
      end
      8'h08:   rd_val[CNT_W-1:0] = count_q;
      8'h0C:   rd_val[IDX_W-1:0] = widx_q;
      8'h10:   rd_val[TS_W-1:0]  = ts_stage_q;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_trig_sched.sv
// Directed self-checking bench for trig_sched. Cycle k of a capture window is
// k clock edges after the edge that commits the START write.
module tb_trig_sched;

  localparam int unsigned N_CH = 17;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [7:0]      paddr = '0;
  logic [31:0]     pwdata = '0;
  logic [31:0]     prdata;
  logic            pready;
  logic            ext_start = 1'b0;
  logic [N_CH-1:0] o_star;
  logic            busy;
  logic            irq;

  int n_total = 0;
  int n_bad   = 0;

  logic [N_CH-1:0] cap_o    [0:31];
  logic            cap_irq  [0:31];
  logic            cap_busy [0:31];
  logic [N_CH-1:0] exp_o    [0:31];
  logic            exp_irq  [0:31];

  always #5 clk = ~clk;

  trig_sched #(.N_CH(17), .DEPTH(16), .TS_W(32), .PW_W(8)) dut (
    .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .ext_start(ext_start), .o_star(o_star), .busy(busy), .irq(irq)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Returns one cycle after the write took effect.
  task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [7:0] a, output logic [31:0] d);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    @(posedge clk); #1;
    penable = 1'b1;
    d = prdata;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic capture(input int n);
    for (int k = 1; k <= n; k++) begin
      if (k > 1) begin
        @(posedge clk); #1;
      end
      cap_o[k]    = o_star;
      cap_irq[k]  = irq;
      cap_busy[k] = busy;
    end
  endtask

  task automatic clear_exp();
    for (int k = 0; k < 32; k++) begin
      exp_o[k]   = '0;
      exp_irq[k] = 1'b0;
    end
  endtask

  task automatic compare_cap(input string tag, input int n);
    for (int k = 1; k <= n; k++) begin
      check($sformatf("%s_o@%0d", tag, k), 32'(cap_o[k]), 32'(exp_o[k]));
      check($sformatf("%s_irq@%0d", tag, k), 32'(cap_irq[k]), 32'(exp_irq[k]));
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic [7:0]  addrs [0:6];
    int          irq_cnt;

    // Reset
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_o_star", 32'(o_star), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_prdata", prdata, 32'h0);
    addrs[0] = 8'h00; addrs[1] = 8'h04; addrs[2] = 8'h08; addrs[3] = 8'h0C;
    addrs[4] = 8'h10; addrs[5] = 8'h14; addrs[6] = 8'h18;
    for (int i = 0; i < 7; i++) begin
      apb_read(addrs[i], rd);
      check($sformatf("rst_reg%02h", addrs[i]), rd, 32'h0);
    end

    // Register readback, unmapped read, WIDX wrap
    apb_write(8'h10, 32'hDEAD_BEEF);
    apb_read(8'h10, rd);
    check("ts_readback", rd, 32'hDEAD_BEEF);
    apb_read(8'h40, rd);
    check("unmapped_rd", rd, 32'h0);
    apb_write(8'h0C, 32'd15);
    apb_write(8'h14, 32'h0000_0000);
    apb_read(8'h0C, rd);
    check("widx_wrap", rd, 32'h0);

    // Single entry: TS=10, mask bit0, width 3. Timer hits 10 in cycle 12.
    apb_write(8'h0C, 32'd0);
    apb_write(8'h10, 32'd10);
    apb_write(8'h14, 32'h0300_0001);
    apb_write(8'h08, 32'd1);
    apb_write(8'h00, 32'h1);
    capture(20);
    clear_exp();
    for (int k = 13; k <= 15; k++) exp_o[k] = 17'h00001;
    exp_irq[17] = 1'b1;
    compare_cap("single", 20);
    check("single_busy1", 32'(cap_busy[1]), 32'h1);
    check("single_busy16", 32'(cap_busy[16]), 32'h1);
    check("single_busy17", 32'(cap_busy[17]), 32'h0);
    apb_read(8'h04, rd);
    check("single_status", rd & 32'h7, 32'h2);
    apb_write(8'h04, 32'h2);
    apb_read(8'h04, rd);
    check("done_w1c", rd & 32'h7, 32'h0);

    // Two entries: second one (TS=2) is already late when reached.
    apb_write(8'h0C, 32'd0);
    apb_write(8'h10, 32'd5);
    apb_write(8'h14, 32'h0001_0000);
    apb_write(8'h10, 32'd2);
    apb_write(8'h14, 32'h0200_0003);
    apb_write(8'h08, 32'd2);
    apb_write(8'h00, 32'h1);
    capture(16);
    clear_exp();
    exp_o[8]  = 17'h10000;
    exp_o[10] = 17'h00003;
    exp_o[11] = 17'h00003;
    exp_irq[13] = 1'b1;
    compare_cap("two", 16);
    check("two_busy12", 32'(cap_busy[12]), 32'h1);
    check("two_busy13", 32'(cap_busy[13]), 32'h0);
    apb_read(8'h04, rd);
    check("two_status", rd & 32'h7, 32'h6);
    apb_write(8'h04, 32'h6);

    // COUNT=0: LOAD -> DONE, irq three cycles after the write.
    apb_write(8'h08, 32'd0);
    apb_write(8'h00, 32'h1);
    capture(5);
    clear_exp();
    exp_irq[3] = 1'b1;
    compare_cap("cnt0", 5);
    check("cnt0_busy2", 32'(cap_busy[2]), 32'h1);
    check("cnt0_busy3", 32'(cap_busy[3]), 32'h0);

    // START and ABORT together: ABORT wins.
    apb_write(8'h00, 32'h3);
    check("start_abort_busy", 32'(busy), 32'h0);

    // LOOP with TS=4, width 1: period = LOAD + 5 WAIT + 1 FIRE + DONE = 8.
    apb_write(8'h0C, 32'd0);
    apb_write(8'h10, 32'd4);
    apb_write(8'h14, 32'h0100_0100);
    apb_write(8'h08, 32'd1);
    apb_write(8'h00, 32'h5);
    capture(16);
    clear_exp();
    exp_o[7]  = 17'h00100;
    exp_o[15] = 17'h00100;
    exp_irq[9] = 1'b1;
    compare_cap("loop", 16);
    check("loop_busy9", 32'(cap_busy[9]), 32'h1);
    // Dropped while busy (cycles 17-18), then ABORT in cycle 21 (WAIT).
    apb_write(8'h08, 32'd5);
    apb_write(8'h00, 32'h2);
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_o_star", 32'(o_star), 32'h0);
    capture(12);
    clear_exp();
    compare_cap("post_abort", 12);
    apb_read(8'h08, rd);
    check("count_locked", rd, 32'd1);
    apb_read(8'h04, rd);
    check("abort_status", rd & 32'h3, 32'h2);

`ifdef TRIG_SCHED_EXT_START_EN
    @(posedge clk); #1;
    ext_start = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("ext_busy_c2", 32'(busy), 32'h0);
    @(posedge clk); #1;
    check("ext_busy_c3", 32'(busy), 32'h1);
    irq_cnt = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (irq) irq_cnt++;
    end
    check("ext_irq_cnt", 32'(irq_cnt), 32'd1);
    check("ext_no_restart", 32'(busy), 32'h0);
    ext_start = 1'b0;
`else
    irq_cnt = 0;
    ext_start = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (busy) irq_cnt++;
    end
    check("ext_ignored", 32'(irq_cnt), 32'd0);
    ext_start = 1'b0;
`endif

    // Reset in the middle of a pulse.
    apb_write(8'h00, 32'h1);
    capture(7);
    check("pre_rst_pulse", 32'(cap_o[7]), 32'h100);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_o_star", 32'(o_star), 32'h0);
    check("rst_mid_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    apb_read(8'h08, rd);
    check("rst_mid_count", rd, 32'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
